cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multicycle control unit for the simple accumulator CPU. It sequences fetch, decode and execute by pulsing the load-enables of the datapath's enabled registers (PC, IR, MAR, ACC) and by driving a req/ack memory handshake. It sits between the instruction register's opcode field and the datapath enables. A wait-state watchdog halts the core on a hung memory access.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles `mem_req` may stay high without `mem_ack`; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  4  IR[7:4]; stable from DECODE until the instruction completes.
- acc_zero  in  1  ACC == 0 flag from the datapath.
- mem_ack  in  1  memory completion; sampled only while `mem_req`=1.
- pc_en  out  1  PC load-enable.
- pc_sel  out  1  PC source: 0 = PC+1, 1 = IR operand.
- ir_en  out  1  IR load-enable.
- mar_en  out  1  MAR load-enable.
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR operand.
- acc_en  out  1  ACC load-enable.
- alu_op  out  2  00 = pass memory data, 01 = ACC+mem, 10 = ACC-mem.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only with `mem_req`.
- halted  out  1  core stopped.
- bus_err  out  1  sticky; watchdog expired.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- retired  out  16  retired-instruction count; present only with CTRL_RETIRE_CNT_EN.

## Operation
- States: FETCH_ADDR, FETCH_WAIT, DECODE, MEM_WAIT, HALT. Reset state is FETCH_ADDR.
- Output rules:
  - All outputs are 0 unless stated below, including while `rst` is high.
  - Enables are decoded from the state register, and from `mem_ack` where noted (Mealy).
- FETCH_ADDR:
  - Drives `mar_en`=1, `mar_sel`=0.
  - Next state: FETCH_WAIT.
- FETCH_WAIT:
  - Drives `mem_req`=1, `mem_we`=0.
  - On `mem_ack`: drives `ir_en`=1, `pc_en`=1, `pc_sel`=0, then goes to DECODE.
- DECODE, by opcode:
  - 0 NOP: go to FETCH_ADDR.
  - 1 LOAD, 2 STORE, 3 ADD, 4 SUB: drive `mar_en`=1, `mar_sel`=1, then go to MEM_WAIT.
  - 5 JMP: drive `pc_en`=1, `pc_sel`=1, then go to FETCH_ADDR.
  - 6 JZ: if `acc_zero`=1, behave as JMP; otherwise behave as NOP.
  - 7 HALT: go to HALT.
  - 8–15: drive `illegal`=1 for this cycle and behave as NOP.
- MEM_WAIT:
  - Drives `mem_req`=1; `mem_we`=1 only for STORE.
  - On `mem_ack`: LOAD/ADD/SUB drive `acc_en`=1 with `alu_op` = 00/01/10 respectively; STORE drives no enable. Then go to FETCH_ADDR.
- HALT:
  - `halted`=1 and all enables stay 0.
  - Exit only through `rst`.
- Watchdog:
  - An 8-bit wait counter clears on entering FETCH_WAIT or MEM_WAIT and increments each wait cycle without `mem_ack`.
  - When `mem_req` has been high for TIMEOUT cycles with no ack, the next state is HALT and `bus_err` is set to 1.
  - An ack arriving in the TIMEOUT-th cycle is accepted normally.
- Reset mid-operation (including mid-handshake): `mem_req` drops immediately and the FSM restarts at FETCH_ADDR; `bus_err` and `retired` clear.

## Timing
- With zero-wait memory (ack in the first `mem_req` cycle), cycles per instruction are:
  - NOP, JMP, JZ: 3.
  - LOAD, STORE, ADD, SUB: 4.
  - HALT: 3, then `halted`=1 from the 4th cycle.
- Each memory wait cycle adds 1 cycle.
- At most one of `pc_en`, `ir_en`, `mar_en`, `acc_en` is high per cycle, except during a fetch ack, where `ir_en` and `pc_en` are high together.
- Enables are single-cycle pulses; the datapath captures on the edge that ends the cycle.

## Configuration
- Macro: CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds the `retired` output, a 16-bit register that resets to 0.
  - It increments on the edge that completes an instruction: the DECODE→FETCH_ADDR, DECODE→HALT and MEM_WAIT→FETCH_ADDR transitions.
  - It saturates at 16'hFFFF.
  - Watchdog entry to HALT does not count.
- Undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset then fetch of NOP (0x0) with zero-wait memory:
  - `mar_en` high in cycle 0, `ir_en` and `pc_en` high in cycle 1, back at FETCH_ADDR in cycle 3.
  - `retired`=1 when CTRL_RETIRE_CNT_EN is defined.
- LOAD with 2 wait cycles:
  - `mem_req` high for 3 cycles in MEM_WAIT.
  - `acc_en`=1 with `alu_op`=00 on the ack cycle; total 6 cycles.
- STORE: `mem_we`=1 during MEM_WAIT only; `acc_en` never asserts.
- JZ with `acc_zero`=0, then with `acc_zero`=1:
  - First case: no `pc_sel`=1 pulse.
  - Second case: DECODE drives `pc_en`=1, `pc_sel`=1.
- Opcode 0xB: `illegal` is high for exactly 1 cycle and execution continues.
- TIMEOUT=4, `mem_ack` held 0 in FETCH_WAIT:
  - `mem_req` high 4 cycles, then `halted`=1 and `bus_err`=1.
  - Asserting `rst` mid-wait instead clears everything and restarts at FETCH_ADDR.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle fetch/decode/execute sequencer with req/ack memory handshake and wait-state watchdog.
// 3-4 cycles per instruction plus memory wait cycles; `define CTRL_RETIRE_CNT_EN adds the retired counter.
module cpu_ctrl_fsm #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        acc_zero,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        ir_en,
    output logic        mar_en,
    output logic        mar_sel,
    output logic        acc_en,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        MEM_WAIT   = 3'd3,
        HALT       = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_JZ    = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Counter value seen during the TIMEOUT-th request cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       bus_err_q;
    logic       wd_fire;
    logic       wait_state;

    assign wait_state = (state == FETCH_WAIT) || (state == MEM_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_ADDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts unacknowledged request cycles; cleared in every non-wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (wait_state) begin
            if (!mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (wd_fire) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;

    always_comb begin
        state_nxt = state;
        wd_fire   = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        ir_en     = 1'b0;
        mar_en    = 1'b0;
        mar_sel   = 1'b0;
        acc_en    = 1'b0;
        alu_op    = ALU_PASS;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;

        case (state)
            FETCH_ADDR: begin
                mar_en    = 1'b1;
                state_nxt = FETCH_WAIT;
            end

            FETCH_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en     = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    wd_fire   = 1'b1;
                    state_nxt = HALT;
                end
            end

            DECODE: begin
                state_nxt = FETCH_ADDR;
                case (opcode)
                    OP_NOP: ;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
                        mar_en    = 1'b1;
                        mar_sel   = 1'b1;
                        state_nxt = MEM_WAIT;
                    end
                    OP_JMP: begin
                        pc_en  = 1'b1;
                        pc_sel = 1'b1;
                    end
                    OP_JZ: begin
                        pc_en  = acc_zero;
                        pc_sel = acc_zero;
                    end
                    OP_HALT: state_nxt = HALT;
                    default: illegal = 1'b1;
                endcase
            end

            MEM_WAIT: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ack) begin
                    state_nxt = FETCH_ADDR;
                    case (opcode)
                        OP_LOAD: begin
                            acc_en = 1'b1;
                            alu_op = ALU_PASS;
                        end
                        OP_ADD: begin
                            acc_en = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        OP_SUB: begin
                            acc_en = 1'b1;
                            alu_op = ALU_SUB;
                        end
                        default: ;
                    endcase
                end else if (wait_cnt == WAIT_LAST) begin
                    wd_fire   = 1'b1;
                    state_nxt = HALT;
                end
            end

            HALT: halted = 1'b1;

            default: state_nxt = FETCH_ADDR;
        endcase

        // Reset forces every decoded output low, even though the state is already FETCH_ADDR.
        if (rst) begin
            pc_en   = 1'b0;
            pc_sel  = 1'b0;
            ir_en   = 1'b0;
            mar_en  = 1'b0;
            mar_sel = 1'b0;
            acc_en  = 1'b0;
            alu_op  = ALU_PASS;
            mem_req = 1'b0;
            mem_we  = 1'b0;
            halted  = 1'b0;
            illegal = 1'b0;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic        complete;
    logic [15:0] retired_q;

    // Watchdog entry to HALT comes from a wait state, so it never counts here.
    assign complete = ((state == DECODE) && (state_nxt != MEM_WAIT)) ||
                      ((state == MEM_WAIT) && (state_nxt == FETCH_ADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (complete && (retired_q != 16'hFFFF)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed cycle-by-cycle bench for cpu_ctrl_fsm with TIMEOUT=4 and zero/short-wait memory.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        acc_zero;
    logic        mem_ack;
    logic        pc_en, pc_sel, ir_en, mar_en, mar_sel, acc_en;
    logic [1:0]  alu_op;
    logic        mem_req, mem_we, halted, bus_err, illegal;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int errs   = 0;
    int checks = 0;

    cpu_ctrl_fsm #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .acc_zero (acc_zero),
        .mem_ack  (mem_ack),
        .pc_en    (pc_en),
        .pc_sel   (pc_sel),
        .ir_en    (ir_en),
        .mar_en   (mar_en),
        .mar_sel  (mar_sel),
        .acc_en   (acc_en),
        .alu_op   (alu_op),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .halted   (halted),
        .bus_err  (bus_err),
        .illegal  (illegal)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {pc_en,pc_sel,ir_en,mar_en,mar_sel,acc_en,alu_op,mem_req,mem_we,halted,bus_err,illegal}
    localparam logic [12:0] B_PC_EN   = 13'h1000;
    localparam logic [12:0] B_PC_SEL  = 13'h0800;
    localparam logic [12:0] B_IR_EN   = 13'h0400;
    localparam logic [12:0] B_MAR_EN  = 13'h0200;
    localparam logic [12:0] B_MAR_SEL = 13'h0100;
    localparam logic [12:0] B_ACC_EN  = 13'h0080;
    localparam logic [12:0] B_ALU_ADD = 13'h0020;
    localparam logic [12:0] B_ALU_SUB = 13'h0040;
    localparam logic [12:0] B_MEM_REQ = 13'h0010;
    localparam logic [12:0] B_MEM_WE  = 13'h0008;
    localparam logic [12:0] B_HALTED  = 13'h0004;
    localparam logic [12:0] B_BUS_ERR = 13'h0002;
    localparam logic [12:0] B_ILLEGAL = 13'h0001;

    localparam logic [12:0] O_NONE = 13'h0000;
    localparam logic [12:0] O_FA   = B_MAR_EN;
    localparam logic [12:0] O_FW   = B_MEM_REQ;
    localparam logic [12:0] O_FACK = B_MEM_REQ | B_IR_EN | B_PC_EN;
    localparam logic [12:0] O_DMEM = B_MAR_EN | B_MAR_SEL;
    localparam logic [12:0] O_DJMP = B_PC_EN | B_PC_SEL;
    localparam logic [12:0] O_MW   = B_MEM_REQ;

    logic [12:0] obs;
    assign obs = {pc_en, pc_sel, ir_en, mar_en, mar_sel, acc_en, alu_op,
                  mem_req, mem_we, halted, bus_err, illegal};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, want, $time);
        end
    endtask

    // Called just after a rising edge; drives inputs, checks mid-cycle, returns just after the next edge.
    task automatic tick(input logic [3:0] op, input logic az, input logic ack,
                        input logic [12:0] want, input string tag);
        opcode   = op;
        acc_zero = az;
        mem_ack  = ack;
        #3;
        chk(tag, {3'b000, obs}, {3'b000, want});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op, input string tag);
        tick(op, 1'b0, 1'b0, O_FA,   {tag, "_fa"});
        tick(op, 1'b0, 1'b1, O_FACK, {tag, "_fack"});
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #3;
        chk({tag, "_outs"}, {3'b000, obs}, 16'h0000);
`ifdef CTRL_RETIRE_CNT_EN
        chk({tag, "_retired"}, retired, 16'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = 4'd0;
        acc_zero = 1'b0;
        mem_ack  = 1'b1;
        @(posedge clk);
        #1;
        tick(4'd0, 1'b0, 1'b1, O_NONE, "reset_held");
        rst = 1'b0;

        // NOP, zero wait
        fetch(4'h0, "nop");
        tick(4'h0, 1'b0, 1'b0, O_NONE, "nop_dec");
`ifdef CTRL_RETIRE_CNT_EN
        #3 chk("nop_retired", retired, 16'd1);
        #0;
        @(posedge clk); #1;
        // The extra cycle above was FETCH_ADDR; fall into FETCH_WAIT
        tick(4'h1, 1'b0, 1'b1, O_FACK, "load_fack");
`else
        fetch(4'h1, "load");
`endif
        // LOAD with two wait cycles
        tick(4'h1, 1'b0, 1'b0, O_DMEM, "load_dec");
        tick(4'h1, 1'b0, 1'b0, O_MW, "load_w0");
        tick(4'h1, 1'b0, 1'b0, O_MW, "load_w1");
        tick(4'h1, 1'b0, 1'b1, O_MW | B_ACC_EN, "load_ack");

        fetch(4'h2, "store");
        tick(4'h2, 1'b0, 1'b0, O_DMEM, "store_dec");
        tick(4'h2, 1'b0, 1'b1, O_MW | B_MEM_WE, "store_ack");

        fetch(4'h3, "add");
        tick(4'h3, 1'b0, 1'b0, O_DMEM, "add_dec");
        tick(4'h3, 1'b0, 1'b1, O_MW | B_ACC_EN | B_ALU_ADD, "add_ack");

        fetch(4'h4, "sub");
        tick(4'h4, 1'b0, 1'b0, O_DMEM, "sub_dec");
        tick(4'h4, 1'b0, 1'b1, O_MW | B_ACC_EN | B_ALU_SUB, "sub_ack");

        fetch(4'h6, "jz0");
        tick(4'h6, 1'b0, 1'b0, O_NONE, "jz0_dec");
        fetch(4'h6, "jz1");
        tick(4'h6, 1'b1, 1'b0, O_DJMP, "jz1_dec");
        fetch(4'h5, "jmp");
        tick(4'h5, 1'b0, 1'b0, O_DJMP, "jmp_dec");

        fetch(4'hB, "ill");
        tick(4'hB, 1'b0, 1'b0, B_ILLEGAL, "ill_dec");

        // Fetch acked in the 4th request cycle is accepted
        tick(4'h0, 1'b0, 1'b0, O_FA, "late_fa");
        tick(4'h0, 1'b0, 1'b0, O_FW, "late_w0");
        tick(4'h0, 1'b0, 1'b0, O_FW, "late_w1");
        tick(4'h0, 1'b0, 1'b0, O_FW, "late_w2");
        tick(4'h0, 1'b0, 1'b1, O_FACK, "late_ack");
        tick(4'h0, 1'b0, 1'b0, O_NONE, "late_dec");
`ifdef CTRL_RETIRE_CNT_EN
        #3 chk("ten_retired", retired, 16'd10);
        @(posedge clk); #1;
        tick(4'h0, 1'b0, 1'b0, O_FW, "mid_w0");
`else
        tick(4'h0, 1'b0, 1'b0, O_FA, "mid_fa");
`endif
        // Reset in the middle of a handshake
        tick(4'h0, 1'b0, 1'b0, O_FW, "mid_w1");
        do_reset("mid_rst");
        fetch(4'h0, "post_rst");
        tick(4'h0, 1'b0, 1'b0, O_NONE, "post_rst_dec");

        // Watchdog: no ack for 4 request cycles
        tick(4'h0, 1'b0, 1'b0, O_FA, "wd_fa");
        for (int i = 0; i < 4; i++) tick(4'h0, 1'b0, 1'b0, O_FW, $sformatf("wd_w%0d", i));
        tick(4'h0, 1'b0, 1'b0, B_HALTED | B_BUS_ERR, "wd_halt");
        tick(4'h0, 1'b0, 1'b1, B_HALTED | B_BUS_ERR, "wd_stay");
`ifdef CTRL_RETIRE_CNT_EN
        chk("wd_retired", retired, 16'd1);
`endif

        // HALT instruction: halted from the 4th cycle, bus_err cleared by reset
        do_reset("halt_rst");
        fetch(4'h7, "halt");
        tick(4'h7, 1'b0, 1'b0, O_NONE, "halt_dec");
        tick(4'h7, 1'b0, 1'b0, B_HALTED, "halt_state");
        tick(4'h0, 1'b0, 1'b1, B_HALTED, "halt_hold");
`ifdef CTRL_RETIRE_CNT_EN
        chk("halt_retired", retired, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
